// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM state encoding and direction constants for the I2C transaction sequencer
package i2c_pkg;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;
  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_WR_DATA,
    S_WR_BYTE,
    S_RD_BYTE,
    S_RD_WAIT,
    S_RD_SINK,
    S_STOP,
    S_STOP_WAIT
  } state_t;
endpackage

// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: turns one request into start/address/data/stop command pulses for a byte-level I2C core
module i2c_txn_sequencer
  import i2c_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [6:0]       req_addr,
  input  logic             req_rw,
  input  logic [LEN_W-1:0] req_len,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [7:0]       tx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [7:0]       rx_data,
  output logic             txn_done,
  output logic             txn_err,
  output logic             core_start,
  output logic             core_stop,
  output logic             core_write,
  output logic             core_read_ack,
  output logic             core_read_nack,
  output logic [7:0]       core_txdata,
  input  logic [7:0]       core_rxdata,
  input  logic             core_buzy,
  input  logic             core_ack_fail,
  input  logic             core_start_done,
  input  logic             core_stop_done,
  input  logic             core_tx_done,
  input  logic             core_rx_done
);
  state_t             r_state;
  state_t             w_next;
  logic               r_pend;
  logic [6:0]         r_addr;
  logic               r_rw;
  logic [LEN_W-1:0]   r_cnt;
  logic               r_err;
  logic [7:0]         r_txdata;
  logic [7:0]         r_rxdata;
  logic               r_done;
  logic               r_done_err;
  logic               w_accept;
  logic               w_start;
  logic               w_write;
  logic               w_rack;
  logic               w_rnack;
  logic               w_stop;
  logic               w_load_addr;
  logic               w_tx_take;
  logic               w_rx_take;
  logic               w_dec;
  logic               w_set_err;
  logic               w_finish;
  logic               w_last;

  assign w_last = (r_cnt == LEN_W'(1));

  // next state and command decode; r_pend marks a state whose command is still owed to the core
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_start     = 1'b0;
    w_write     = 1'b0;
    w_rack      = 1'b0;
    w_rnack     = 1'b0;
    w_stop      = 1'b0;
    w_load_addr = 1'b0;
    w_tx_take   = 1'b0;
    w_rx_take   = 1'b0;
    w_dec       = 1'b0;
    w_set_err   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = req_valid;
        w_next   = req_valid ? S_START : S_IDLE;
      end
      S_START: begin
        w_start = r_pend & ~core_buzy;
        if (!r_pend && core_start_done) begin
          w_load_addr = 1'b1;
          w_next      = S_ADDR;
        end
      end
      S_ADDR: begin
        w_write = r_pend & ~core_buzy;
        if (!r_pend && core_tx_done) begin
          w_set_err = core_ack_fail;
          w_next    = (core_ack_fail || r_cnt == '0) ? S_STOP :
                      (r_rw == I2C_RW_READ) ? S_RD_BYTE : S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        w_tx_take = tx_valid;
        w_next    = tx_valid ? S_WR_BYTE : S_WR_DATA;
      end
      S_WR_BYTE: begin
        w_write = r_pend & ~core_buzy;
        if (!r_pend && core_tx_done) begin
          w_set_err = core_ack_fail;
          w_dec     = ~core_ack_fail;
          w_next    = (core_ack_fail || w_last) ? S_STOP : S_WR_DATA;
        end
      end
      S_RD_BYTE: begin
        w_rnack = ~core_buzy & w_last;
        w_rack  = ~core_buzy & ~w_last;
        w_next  = core_buzy ? S_RD_BYTE : S_RD_WAIT;
      end
      S_RD_WAIT: begin
        w_rx_take = core_rx_done;
        w_dec     = core_rx_done;
        w_next    = core_rx_done ? S_RD_SINK : S_RD_WAIT;
      end
      S_RD_SINK: w_next = !rx_ready ? S_RD_SINK : (r_cnt == '0) ? S_STOP : S_RD_BYTE;
      S_STOP: begin
        w_stop = ~core_buzy;
        w_next = core_buzy ? S_STOP : S_STOP_WAIT;
      end
      S_STOP_WAIT: begin
        w_finish = core_stop_done;
        w_next   = core_stop_done ? S_IDLE : S_STOP_WAIT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // state register; reset abandons any transaction without issuing a stop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  end

  // request latches, byte counter, data holding and completion reporting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend     <= 1'b0;
      r_addr     <= '0;
      r_rw       <= 1'b0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_txdata   <= '0;
      r_rxdata   <= '0;
      r_done     <= 1'b0;
      r_done_err <= 1'b0;
    end else begin
      r_pend <= (w_next != r_state) | (r_pend & ~(w_start | w_write));
      if (w_accept) begin
        r_addr <= req_addr;
        r_rw   <= req_rw;
        r_cnt  <= req_len;
      end else if (w_dec) begin
        r_cnt <= r_cnt - LEN_W'(1);
      end
      if (w_load_addr) r_txdata <= {r_addr, r_rw};
      else if (w_tx_take) r_txdata <= tx_data;
      if (w_rx_take) r_rxdata <= core_rxdata;
      r_err      <= w_finish ? 1'b0 : (r_err | w_set_err);
      r_done     <= w_finish;
      r_done_err <= w_finish & r_err;
    end
  end

  assign req_ready      = (r_state == S_IDLE);
  assign tx_ready       = w_tx_take;
  assign rx_valid       = (r_state == S_RD_SINK);
  assign rx_data        = r_rxdata;
  assign txn_done       = r_done;
  assign txn_err        = r_done_err;
  assign core_start     = w_start;
  assign core_stop      = w_stop;
  assign core_write     = w_write;
  assign core_read_ack  = w_rack;
  assign core_read_nack = w_rnack;
  assign core_txdata    = r_txdata;
endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// tb_i2c_txn_sequencer: directed and randomized transactions against a behavioural I2C core and sink/source
module tb_i2c_txn_sequencer;
  localparam int C_START = 1, C_WRITE = 2, C_RACK = 3, C_RNACK = 4, C_STOP = 5;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0, req_ready;
  logic [6:0] req_addr = '0;
  logic       req_rw = 1'b0;
  logic [7:0] req_len = '0;
  logic       tx_valid = 1'b0, tx_ready;
  logic [7:0] tx_data = '0;
  logic       rx_valid, rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       txn_done, txn_err;
  logic       core_start, core_stop, core_write, core_read_ack, core_read_nack;
  logic [7:0] core_txdata, core_rxdata = '0;
  logic       core_buzy = 1'b0, core_ack_fail = 1'b0;
  logic       core_start_done = 1'b0, core_stop_done = 1'b0, core_tx_done = 1'b0, core_rx_done = 1'b0;
  int tests = 0, fails = 0;
  logic [15:0] cmd_log[$];
  logic [7:0]  tx_q[$], rd_q[$], tx_got[$], rx_got[$], pre_w[$], pre_r[$];
  int busy_cnt = 0, pcmd = 0, wr_idx = 0, nack_at = 255, hold_arm = 0, hold_left = 0;
  int stall = 0, rd_in_sink = 0, done_cnt = 0;
  bit last_err = 0, tx_ready_seen = 0, tx_always = 0, rx_pend = 0;
  logic [7:0] rx_prev = '0, wr_hold = '0;

  i2c_txn_sequencer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_rw(req_rw), .req_len(req_len),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .txn_done(txn_done), .txn_err(txn_err),
    .core_start(core_start), .core_stop(core_stop), .core_write(core_write),
    .core_read_ack(core_read_ack), .core_read_nack(core_read_nack),
    .core_txdata(core_txdata), .core_rxdata(core_rxdata), .core_buzy(core_buzy),
    .core_ack_fail(core_ack_fail), .core_start_done(core_start_done), .core_stop_done(core_stop_done),
    .core_tx_done(core_tx_done), .core_rx_done(core_rx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    if (obs !== expv) begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  initial begin
    int code;
    forever begin
      @(negedge clk);
      code = 0;
      if (!reset) begin
        code = core_start ? C_START : core_write ? C_WRITE : core_read_ack ? C_RACK :
               core_read_nack ? C_RNACK : core_stop ? C_STOP : 0;
        if (code != 0) begin
          chk("cmd_single_not_busy", int'(core_start) + int'(core_stop) + int'(core_write) + int'(core_read_ack) + int'(core_read_nack) + (core_buzy ? 10 : 0), 1);
          cmd_log.push_back({8'(code), (code == C_WRITE) ? core_txdata : 8'h00});
          if (code == C_WRITE) wr_hold = core_txdata;
          if (rx_valid && (code == C_RACK || code == C_RNACK)) rd_in_sink++;
        end
        if (busy_cnt > 0 && pcmd == C_WRITE) chk("core_txdata_stable", core_txdata, wr_hold);
        if (tx_ready) tx_ready_seen = 1;
        if (tx_valid && tx_ready) begin
          tx_got.push_back(tx_data);
          tx_q.delete(0);
        end
        if (rx_pend) chk("rx_valid_held", rx_valid, 1'b1);
        if (rx_valid) begin
          if (rx_pend) chk("rx_data_held", rx_data, rx_prev);
          if (rx_ready) begin
            rx_got.push_back(rx_data);
            rx_pend = 0;
          end else begin
            rx_pend = 1;
            rx_prev = rx_data;
            stall++;
          end
        end else begin
          rx_pend = 0;
        end
        if (txn_done) begin
          done_cnt++;
          last_err = txn_err;
        end
      end
      @(posedge clk);
      #1;
      core_start_done = 0;
      core_stop_done  = 0;
      core_tx_done    = 0;
      core_rx_done    = 0;
      core_ack_fail   = 1'($urandom_range(0, 1));
      core_rxdata     = 8'($urandom);
      if (reset) begin
        busy_cnt  = 0;
        core_buzy = 0;
        rx_pend   = 0;
        hold_left = 0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          core_buzy = 0;
          if (pcmd == C_START) core_start_done = 1;
          else if (pcmd == C_STOP) core_stop_done = 1;
          else if (pcmd == C_WRITE) begin
            core_tx_done  = 1;
            core_ack_fail = (wr_idx == nack_at);
            wr_idx++;
          end else begin
            core_rx_done = 1;
            core_rxdata  = 8'h00;
            if (rd_q.size() > 0) core_rxdata = rd_q.pop_front();
          end
        end
      end else if (code != 0) begin
        core_buzy = 1;
        busy_cnt  = $urandom_range(1, 4);
        pcmd      = code;
      end else begin
        core_buzy = ($urandom_range(0, 3) == 0);
      end
      if (hold_left > 0) hold_left--;
      if (hold_arm > 0 && rx_valid) begin
        hold_left = hold_arm;
        hold_arm  = 0;
      end
      rx_ready = (hold_arm > 0 || hold_left > 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
      tx_valid = (tx_q.size() > 0) && (tx_always || $urandom_range(0, 2) != 0);
      tx_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    end
  end

  task automatic run_txn(input logic [6:0] a, input logic rw, input int len, input int nack, input int hold);
    logic [15:0] exp_log[$];
    logic [7:0]  wq[$], rq[$];
    int d0, nwr, nrx;
    bit exp_err;
    @(posedge clk);
    #2;
    cmd_log.delete(); tx_got.delete(); rx_got.delete(); tx_q.delete(); rd_q.delete();
    for (int i = 0; i < len; i++) begin
      wq.push_back(i < pre_w.size() ? pre_w[i] : 8'($urandom));
      rq.push_back(i < pre_r.size() ? pre_r[i] : 8'($urandom));
    end
    pre_w.delete();
    pre_r.delete();
    tx_q = wq;
    rd_q = rq;
    nack_at = nack; wr_idx = 0; tx_ready_seen = 0; stall = 0; rd_in_sink = 0; hold_arm = hold;
    tx_always = rw || nack == 0 || len == 0;
    d0 = done_cnt;
    req_valid = 1; req_addr = a; req_rw = rw; req_len = 8'(len);
    @(posedge clk);
    #2;
    req_addr = ~a; req_rw = ~rw; req_len = 8'(len + 1);
    @(negedge clk);
    chk("req_ready_busy", req_ready, 1'b0);
    @(posedge clk);
    #2;
    req_valid = 0;
    for (int i = 0; i < 4000 && done_cnt == d0; i++) @(negedge clk);
    chk("txn_done_seen", done_cnt, d0 + 1);
    exp_err = 0;
    nwr = 0;
    exp_log.push_back({8'(C_START), 8'h00});
    exp_log.push_back({8'(C_WRITE), a, rw});
    if (nack == 0) exp_err = 1;
    else if (!rw) begin
      for (int i = 0; i < len; i++) begin
        exp_log.push_back({8'(C_WRITE), wq[i]});
        nwr++;
        if (nack == i + 1) begin
          exp_err = 1;
          break;
        end
      end
    end else begin
      for (int i = 0; i < len; i++) exp_log.push_back({8'((i == len - 1) ? C_RNACK : C_RACK), 8'h00});
    end
    exp_log.push_back({8'(C_STOP), 8'h00});
    nrx = (rw && nack != 0) ? len : 0;
    chk("txn_err", last_err, exp_err);
    chk("cmd_count", cmd_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < cmd_log.size(); i++) chk($sformatf("cmd[%0d]", i), cmd_log[i], exp_log[i]);
    chk("tx_bytes_taken", tx_got.size(), nwr);
    if (nwr == 0) chk("tx_ready_never", tx_ready_seen, 1'b0);
    chk("rx_count", rx_got.size(), nrx);
    for (int i = 0; i < nrx && i < rx_got.size(); i++) chk($sformatf("rx[%0d]", i), rx_got[i], rq[i]);
    chk("no_read_cmd_while_rx_valid", rd_in_sink, 0);
    if (hold > 0) chk("rx_stall_cycles", stall >= hold, 1'b1);
  endtask

  initial begin
    int d_before, len, nk, hold;
    logic rw;
    reset = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_outputs", {core_start, core_stop, core_write, core_read_ack, core_read_nack, tx_ready, rx_valid, txn_done, txn_err}, 9'h0);
    chk("rst_data", {core_txdata, rx_data}, 16'h0);
    @(posedge clk);
    #2;
    reset = 0;
    pre_w = '{8'hA5, 8'h3C};
    run_txn(7'h50, 1'b0, 2, 255, 0);
    pre_r = '{8'h11, 8'h22, 8'h33};
    run_txn(7'h50, 1'b1, 3, 255, 0);
    run_txn(7'h2A, 1'b0, 4, 0, 0);
    run_txn(7'h2A, 1'b1, 4, 0, 0);
    run_txn(7'h1F, 1'b0, 0, 255, 0);
    run_txn(7'h1F, 1'b1, 0, 255, 0);
    run_txn(7'h33, 1'b1, 2, 255, 20);
    run_txn(7'h44, 1'b0, 3, 3, 0);
    run_txn(7'h45, 1'b0, 3, 1, 0);
    @(posedge clk);
    #2;
    cmd_log.delete();
    tx_q = '{8'h01, 8'h02, 8'h03};
    nack_at = 255; wr_idx = 0; tx_always = 1;
    d_before = done_cnt;
    req_valid = 1; req_addr = 7'h12; req_rw = 1'b0; req_len = 8'd3;
    @(posedge clk);
    #2;
    req_valid = 0;
    for (int i = 0; i < 200 && cmd_log.size() < 3; i++) @(negedge clk);
    chk("mid_txn_reached", cmd_log.size(), 3);
    @(posedge clk);
    #2;
    reset = 1;
    @(negedge clk);
    chk("rst_mid_idle", req_ready, 1'b1);
    chk("rst_mid_cmds", {core_start, core_stop, core_write, core_read_ack, core_read_nack}, 5'h0);
    chk("rst_mid_flags", {txn_done, tx_ready, rx_valid}, 3'h0);
    repeat (2) @(posedge clk);
    #2;
    reset = 0;
    chk("rst_mid_no_done", done_cnt, d_before);
    run_txn(7'h12, 1'b0, 3, 255, 0);
    for (int t = 0; t < 12; t++) begin
      len  = $urandom_range(0, 6);
      rw   = 1'($urandom_range(0, 1));
      nk   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : 255;
      hold = (rw && len > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(3, 10) : 0;
      run_txn(7'($urandom), rw, len, nk, hold);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
